// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the RMII MAC transmit and receive paths.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_POLY_REF  = 32'hEDB88320;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      SFD,
      DATA,
      PAD,
      FCS,
      IFG
   } tx_state_t;

   // One byte of reflected CRC-32, LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide Ethernet CRC-32 register: init has priority over en.
module eth_crc32
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_q;

   // CRC state: reload on init, fold in one byte per enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= CRC_INIT;
      end else if (init) begin
         crc_q <= CRC_INIT;
      end else if (en) begin
         crc_q <= crc32_byte(crc_q, data);
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/rmii_mac_tx.sv
// RMII transmit MAC: byte stream in, preamble/SFD/payload/pad/FCS dibits out, then IFG.
// State, dcnt and byte_q describe the dibit currently on the wire; the wire registers
// are loaded from the next-state values so TX_EN rises one clock after IDLE sees valid.
module rmii_mac_tx
   import eth_pkg::*;
#(
   parameter int unsigned IFG_BYTES = 12,
   parameter int unsigned MIN_BYTES = 60,
   parameter bit          PAD_EN    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] mac_tx_data,
   input  logic       mac_tx_valid,
   input  logic       mac_tx_last,
   output logic       mac_tx_ready,
   output logic [1:0] rmii_txd,
   output logic       rmii_tx_en,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_underrun
);

   localparam int unsigned      IfgCycles = IFG_BYTES * 4;
   localparam int unsigned      IfgW      = $clog2(IfgCycles + 1);
   // The IDLE cycle before the next preamble is the last gap cycle, so IFG holds one less.
   localparam logic [IfgW-1:0]  IfgLast   = IfgW'(IfgCycles - 2);
   localparam logic [10:0]      MinCnt    = 11'(MIN_BYTES);

   tx_state_t        state_q, state_d;
   logic [1:0]       dcnt_q, dcnt_d;
   logic [7:0]       byte_q, byte_d;
   logic [10:0]      cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [IfgW-1:0]  ifg_q, ifg_d;
   logic             last_q, last_d;
   logic             bad_q, bad_d;
   logic [1:0]       txd_q, txd_d;
   logic             tx_en_q, tx_en_d;
   logic             done_q, done_d;
   logic             crc_en;
   logic [31:0]      crc;
   logic [31:0]      fcs_word;
   logic             slot_end;
   logic             need_pad;
   logic [10:0]      cnt_inc;

   assign slot_end = (dcnt_q == 2'd3);
   assign need_pad = PAD_EN && (cnt_q < MinCnt);
   assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

   eth_crc32 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (state_q == IDLE),
      .en    (crc_en),
      .data  (byte_d),
      .crc   (crc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: transitions happen on byte boundaries, except IDLE and IFG.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (mac_tx_valid) state_d = PREAMBLE;
         PREAMBLE: if (slot_end && idx_q == 3'd6) state_d = SFD;
         SFD:      if (slot_end) state_d = mac_tx_valid ? DATA : FCS;
         DATA: begin
            if (slot_end) begin
               if (last_q) begin
                  state_d = need_pad ? PAD : FCS;
               end else if (!mac_tx_valid) begin
                  state_d = FCS;
               end
            end
         end
         PAD:      if (slot_end && !need_pad) state_d = FCS;
         FCS:      if (slot_end && idx_q == 3'd3) state_d = IFG;
         IFG:      if (ifg_q == IfgLast) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs and datapath next values: byte loads, CRC updates, wire dibit.
   always_comb begin
      dcnt_d   = dcnt_q;
      byte_d   = byte_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      ifg_d    = ifg_q;
      last_d   = last_q;
      bad_d    = bad_q;
      crc_en   = 1'b0;
      fcs_word = 32'h0;

      mac_tx_ready = slot_end && ((state_q == SFD) || (state_q == DATA && !last_q));
      tx_underrun  = mac_tx_ready && !mac_tx_valid;
      tx_busy      = (state_q != IDLE);
      done_d       = (state_q == FCS) && (idx_q == 3'd3) && (dcnt_q == 2'd2);

      if (tx_underrun) bad_d = 1'b1;

      if (state_q == IDLE) begin
         if (state_d == PREAMBLE) begin
            dcnt_d = 2'd0;
            byte_d = PREAMBLE_BYTE;
            cnt_d  = 11'd0;
            idx_d  = 3'd0;
            last_d = 1'b0;
            bad_d  = 1'b0;
         end
      end else if (state_q == IFG) begin
         ifg_d = ifg_q + IfgW'(1);
      end else begin
         dcnt_d = dcnt_q + 2'd1;
         if (slot_end) begin
            case (state_d)
               PREAMBLE: begin
                  byte_d = PREAMBLE_BYTE;
                  idx_d  = idx_q + 3'd1;
               end
               SFD: byte_d = SFD_BYTE;
               DATA: begin
                  byte_d = mac_tx_data;
                  last_d = mac_tx_last;
                  cnt_d  = cnt_inc;
                  crc_en = 1'b1;
               end
               PAD: begin
                  byte_d = 8'h00;
                  cnt_d  = cnt_inc;
                  crc_en = 1'b1;
               end
               FCS: begin
                  idx_d = (state_q == FCS) ? idx_q + 3'd1 : 3'd0;
                  // An underrun sends the un-inverted CRC so the receiver rejects the frame.
                  fcs_word = crc ^ {32{~bad_d}};
                  byte_d   = fcs_word[{idx_d[1:0], 3'b000} +: 8];
               end
               IFG: ifg_d = '0;
               default: ;
            endcase
         end
      end

      tx_en_d = state_d inside {PREAMBLE, SFD, DATA, PAD, FCS};
      txd_d   = tx_en_d ? byte_d[{dcnt_d, 1'b0} +: 2] : 2'b00;
   end

   // Datapath and registered wire outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_q  <= 2'd0;
         byte_q  <= 8'h00;
         cnt_q   <= 11'd0;
         idx_q   <= 3'd0;
         ifg_q   <= '0;
         last_q  <= 1'b0;
         bad_q   <= 1'b0;
         txd_q   <= 2'b00;
         tx_en_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         dcnt_q  <= dcnt_d;
         byte_q  <= byte_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         ifg_q   <= ifg_d;
         last_q  <= last_d;
         bad_q   <= bad_d;
         txd_q   <= txd_d;
         tx_en_q <= tx_en_d;
         done_q  <= done_d;
      end
   end

   assign rmii_txd   = txd_q;
   assign rmii_tx_en = tx_en_q;
   assign tx_done    = done_q;

endmodule

// File: tb/tb_rmii_mac_tx.sv
// Randomised bench for rmii_mac_tx: frames are modelled as byte lists, expanded to
// dibits, and compared against the wire every cycle. Two instances cover PAD_EN=1/0.
module tb_rmii_mac_tx;

   localparam int MINB = 60;
   localparam int IFGC = 48;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] data  = 8'h00;
   logic       valid = 1'b0;
   logic       last  = 1'b0;
   logic       sel   = 1'b0;   // 0: padding instance, 1: no-padding instance
   logic       mon_en = 1'b1;

   logic       ready_p, en_p, busy_p, done_p, und_p;
   logic       ready_n, en_n, busy_n, done_n, und_n;
   logic [1:0] txd_p, txd_n;
   logic       m_ready, m_en, m_busy, m_done, m_und;
   logic [1:0] m_txd;

   int n_chk = 0;
   int n_fail = 0;
   int n_done = 0;
   int n_und = 0;
   int low_run = 0;
   int high_run = 0;
   int last_high = 0;
   int last_gap = 0;
   bit prev_en = 1'b0;
   bit seen_frame = 1'b0;

   logic [7:0] pl [0:1599];
   logic [2:0] exp_q [$];   // {last dibit of frame, dibit}
   logic [2:0] e_dib;

   always #10 clk = ~clk;

   rmii_mac_tx #(.IFG_BYTES(12), .MIN_BYTES(MINB), .PAD_EN(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mac_tx_data  (data),
      .mac_tx_valid (valid && !sel),
      .mac_tx_last  (last),
      .mac_tx_ready (ready_p),
      .rmii_txd     (txd_p),
      .rmii_tx_en   (en_p),
      .tx_busy      (busy_p),
      .tx_done      (done_p),
      .tx_underrun  (und_p)
   );

   rmii_mac_tx #(.IFG_BYTES(12), .MIN_BYTES(MINB), .PAD_EN(1'b0)) dut_np (
      .clk          (clk),
      .rst_n        (rst_n),
      .mac_tx_data  (data),
      .mac_tx_valid (valid && sel),
      .mac_tx_last  (last),
      .mac_tx_ready (ready_n),
      .rmii_txd     (txd_n),
      .rmii_tx_en   (en_n),
      .tx_busy      (busy_n),
      .tx_done      (done_n),
      .tx_underrun  (und_n)
   );

   assign m_ready = sel ? ready_n : ready_p;
   assign m_en    = sel ? en_n    : en_p;
   assign m_busy  = sel ? busy_n  : busy_p;
   assign m_done  = sel ? done_n  : done_p;
   assign m_und   = sel ? und_n   : und_p;
   assign m_txd   = sel ? txd_n   : txd_p;

   function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Expected wire image of one frame, appended to the dibit queue.
   task automatic push_frame(input int base, input int len, input int drop, input bit pad);
      logic [7:0]  fb [$];
      logic [31:0] c;
      logic [31:0] fcs;
      logic [7:0]  bb;
      int n;
      n = (drop >= 0) ? drop : len;
      repeat (7) fb.push_back(8'h55);
      fb.push_back(8'hD5);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         fb.push_back(pl[base + i]);
         c = crc_model(c, pl[base + i]);
      end
      if (drop < 0 && pad) begin
         for (int i = n; i < MINB; i++) begin
            fb.push_back(8'h00);
            c = crc_model(c, 8'h00);
         end
      end
      fcs = (drop >= 0) ? c : ~c;
      for (int k = 0; k < 4; k++) fb.push_back(fcs[8*k +: 8]);
      for (int j = 0; j < fb.size(); j++) begin
         bb = fb[j];
         for (int d = 0; d < 4; d++) begin
            exp_q.push_back({(j == fb.size() - 1 && d == 3), bb[2*d +: 2]});
         end
      end
   endtask

   // Upstream source: valid gaps only between accept slots; drop = byte index to starve.
   task automatic drive_frame(input int base, input int len, input int drop, input bit gaps,
                              input bit hold, input logic [7:0] nxt);
      int i;
      int wd;
      int g;
      i = 0;
      valid = 1'b1;
      data  = pl[base];
      last  = (len == 1);
      while (i < len) begin
         wd = 0;
         @(negedge clk);
         while (!m_ready && wd < 300) begin
            @(negedge clk);
            wd++;
         end
         if (!m_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: ready=%b at byte %0d, required 1", m_ready, i);
            valid = 1'b0;
            last  = 1'b0;
            return;
         end
         if (i == drop) begin
            check("underrun_at_slot", 32'(m_und), 32'd1);
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
         i++;
         if (i < len) begin
            g = gaps ? $urandom_range(0, 3) : 0;
            if (g > 0) begin
               valid = 1'b0;
               data  = 8'($urandom);
               last  = 1'($urandom);
               repeat (g) begin
                  @(posedge clk);
                  #1;
               end
            end
            if (i == drop) begin
               valid = 1'b0;
               data  = 8'($urandom);
            end else begin
               valid = 1'b1;
               data  = pl[base + i];
               last  = (i == len - 1);
            end
         end else if (hold) begin
            valid = 1'b1;
            data  = nxt;
            last  = 1'b0;
         end else begin
            valid = 1'b0;
            last  = 1'b0;
         end
      end
   endtask

   task automatic wait_idle();
      int wd;
      wd = 0;
      @(negedge clk);
      while ((m_busy || m_en) && wd < 8000) begin
         @(negedge clk);
         wd++;
      end
      check("idle_busy", 32'(m_busy), 32'd0);
   endtask

   // Compare process: every cycle the wire must match the expected dibit stream.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_en    <= 1'b0;
         seen_frame <= 1'b0;
         low_run    <= 0;
         high_run   <= 0;
      end else if (mon_en) begin
         if (m_und) n_und <= n_und + 1;
         if (m_done) n_done <= n_done + 1;
         if (m_en) begin
            n_chk <= n_chk + 1;
            if (exp_q.size() == 0) begin
               n_fail <= n_fail + 1;
               $display("FAIL wire_extra: txd=%b on wire, required no frame", m_txd);
            end else begin
               e_dib = exp_q.pop_front();
               if (m_txd !== e_dib[1:0] || m_done !== e_dib[2] || m_busy !== 1'b1) begin
                  n_fail <= n_fail + 1;
                  $display("FAIL wire_dibit: got txd=%b done=%b busy=%b, required txd=%b done=%b busy=1",
                           m_txd, m_done, m_busy, e_dib[1:0], e_dib[2]);
               end
            end
            if (!prev_en) begin
               if (seen_frame && low_run < IFGC) begin
                  n_fail <= n_fail + 1;
                  $display("FAIL ifg_min: gap %0d cycles, required >= %0d", low_run, IFGC);
               end
               last_gap <= low_run;
               high_run <= 1;
            end else begin
               high_run <= high_run + 1;
            end
            prev_en <= 1'b1;
         end else begin
            n_chk <= n_chk + 1;
            if (m_txd !== 2'b00 || m_done !== 1'b0) begin
               n_fail <= n_fail + 1;
               $display("FAIL wire_idle: got txd=%b done=%b, required 00 0", m_txd, m_done);
            end
            if (prev_en) begin
               last_high  <= high_run;
               seen_frame <= 1'b1;
               low_run    <= 1;
            end else begin
               low_run <= low_run + 1;
            end
            prev_en <= 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

   initial begin
      logic [31:0] c;
      int done0;
      int und0;
      int len;

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx_en", 32'(m_en), 32'd0);
      check("reset_txd", 32'(m_txd), 32'd0);
      check("reset_busy", 32'(m_busy), 32'd0);
      check("reset_done", 32'(m_done), 32'd0);
      check("reset_ready", 32'(m_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Pin the reference CRC to the standard check value.
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) c = crc_model(c, 8'(8'h31 + i));
      check("model_check_value", ~c, 32'hCBF43926);

      // 1: no padding, "123456789"
      sel = 1'b1;
      for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
      push_frame(0, 9, -1, 1'b0);
      drive_frame(0, 9, -1, 1'b0, 1'b0, 8'h00);
      wait_idle();
      check("t1_tx_en_cycles", 32'(last_high), 32'd84);

      // 2: single byte padded to 60
      sel = 1'b0;
      pl[0] = 8'hAB;
      push_frame(0, 1, -1, 1'b1);
      drive_frame(0, 1, -1, 1'b0, 1'b0, 8'h00);
      wait_idle();
      check("t2_tx_en_cycles", 32'(last_high), 32'd288);

      // 3: back-to-back 64-byte frames with valid held high
      for (int i = 0; i < 128; i++) pl[i] = 8'($urandom);
      done0 = n_done;
      push_frame(0, 64, -1, 1'b1);
      push_frame(64, 64, -1, 1'b1);
      drive_frame(0, 64, -1, 1'b0, 1'b1, pl[64]);
      drive_frame(64, 64, -1, 1'b0, 1'b0, 8'h00);
      wait_idle();
      check("t3_gap_cycles", 32'(last_gap), 32'd48);
      check("t3_done_pulses", 32'(n_done - done0), 32'd2);
      check("t3_tx_en_cycles", 32'(last_high), 32'd304);

      // 4: starve byte 10, then a good frame
      for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
      und0 = n_und;
      push_frame(0, 64, 10, 1'b1);
      drive_frame(0, 64, 10, 1'b0, 1'b0, 8'h00);
      wait_idle();
      check("t4_underrun_pulses", 32'(n_und - und0), 32'd1);
      check("t4_tx_en_cycles", 32'(last_high), 32'(4 * (8 + 10 + 4)));
      push_frame(0, 20, -1, 1'b1);
      drive_frame(0, 20, -1, 1'b1, 1'b0, 8'h00);
      wait_idle();
      check("t4_good_tx_en_cycles", 32'(last_high), 32'd288);

      // 5: asynchronous reset in the middle of DATA
      mon_en = 1'b0;
      valid = 1'b1;
      data  = 8'h5A;
      last  = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      #3;
      check("t5_pre_reset_tx_en", 32'(m_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_async_tx_en", 32'(m_en), 32'd0);
      check("t5_async_txd", 32'(m_txd), 32'd0);
      check("t5_async_busy", 32'(m_busy), 32'd0);
      valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 70; i++) pl[i] = 8'($urandom);
      push_frame(0, 70, -1, 1'b1);
      drive_frame(0, 70, -1, 1'b1, 1'b0, 8'h00);
      wait_idle();
      check("t5_after_reset_tx_en_cycles", 32'(last_high), 32'(4 * (8 + 70 + 4)));

      // 6: random frames on both instances
      for (int f = 0; f < 200; f++) begin
         sel = f[0];
         len = (f == 100) ? 1514 : $urandom_range(1, 48);
         for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
         push_frame(0, len, -1, !sel);
         drive_frame(0, len, -1, 1'b1, 1'b0, 8'h00);
         wait_idle();
      end

      check("total_underruns", 32'(n_und), 32'd1);
      check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
